// File: rtl/osd_regaccess_master_if.sv
// Command/response and DII flit ports of the OSD register-access master.
// "master" is the view of the osd_regaccess_master block; "slave" is the view of its environment.
interface osd_regaccess_master_if;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:0]  req_dest;
  logic [15:0]  req_addr;
  logic [1:0]   req_size;
  logic [127:0] req_wdata;

  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_status;
  logic [127:0] resp_rdata;

  dii_flit      debug_out;
  logic         debug_out_ready;
  dii_flit      debug_in;
  logic         debug_in_ready;

  modport master (
    input  req_valid, req_write, req_dest, req_addr, req_size, req_wdata,
    input  resp_ready, debug_out_ready, debug_in,
    output req_ready, resp_valid, resp_status, resp_rdata, debug_out, debug_in_ready
  );

  modport slave (
    output req_valid, req_write, req_dest, req_addr, req_size, req_wdata,
    output resp_ready, debug_out_ready, debug_in,
    input  req_ready, resp_valid, resp_status, resp_rdata, debug_out, debug_in_ready
  );
endinterface

// File: rtl/osd_regaccess_master.sv
// OSD register-access initiator: sends one REG request packet over DII, waits for the
// matching response and returns status and read data. One transaction outstanding at a time.
module osd_regaccess_master #(
  parameter int unsigned MAX_REG_SIZE   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            id,
  osd_regaccess_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StTx, StRxHdr, StRxBody, StRxDrop, StResp} state_e;

  localparam logic [1:0] StatusOk     = 2'd0;
  localparam logic [1:0] StatusTarget = 2'd1;
  localparam logic [1:0] StatusTmo    = 2'd2;
  localparam logic [1:0] StatusProto  = 2'd3;

  // Counter saturates here; reaching it on the next edge is the timeout event.
  localparam logic [TIMEOUT_WIDTH-1:0] ToLimit =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [3:0]               tx_idx_q, tx_idx_d;
  logic [1:0]               hdr_idx_q, hdr_idx_d;
  logic [3:0]               body_cnt_q, body_cnt_d;
  logic                     drop_to_resp_q, drop_to_resp_d;
  logic                     write_q, write_d;
  logic [15:0]              dest_q, dest_d;
  logic [15:0]              addr_q, addr_d;
  logic [1:0]               size_q, size_d;
  logic [127:0]             wdata_q, wdata_d;
  logic [1:0]               status_q, status_d;
  logic [127:0]             rdata_q, rdata_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0]  nwords;
  logic [3:0]  tx_last_idx;
  logic        too_big;
  logic        in_hs;
  logic        in_last;
  logic [1:0]  in_type;
  logic [3:0]  in_sub;
  logic        timed_out;
  logic        flags_body;
  logic [1:0]  flags_status;
  logic        out_valid;
  logic        out_last;
  logic [15:0] out_data;

  assign nwords      = 4'd1 << size_q;
  assign tx_last_idx = write_q ? (4'd3 + nwords) : 4'd3;
  assign too_big     = (32'd16 << bus.req_size) > MAX_REG_SIZE;
  assign in_hs       = bus.debug_in.valid && bus.debug_in_ready;
  assign in_last     = bus.debug_in.last;
  assign in_type     = bus.debug_in.data[15:14];
  assign in_sub      = bus.debug_in.data[13:10];
  assign timed_out   = (TIMEOUT_CYCLES != 0) && (cnt_q >= ToLimit);

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.debug_in_ready = (state_q != StResp);
  assign bus.resp_valid     = (state_q == StResp);
  assign bus.resp_status    = status_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.debug_out      = {out_valid, out_last, out_data};

  // Egress flit mux; write data is pre-aligned so the current word is always on top.
  always_comb begin
    out_valid = (state_q == StTx);
    out_last  = (state_q == StTx) && (tx_idx_q == tx_last_idx);
    out_data  = wdata_q[127:112];
    case (tx_idx_q)
      4'd0:    out_data = dest_q;
      4'd1:    out_data = id;
      4'd2:    out_data = {2'b00, write_q ? {2'b01, size_q} : {2'b00, size_q}, 10'b0};
      4'd3:    out_data = addr_q;
      default: out_data = wdata_q[127:112];
    endcase
  end

  // Classify a matched response FLAGS flit (TYPE already known to be 0).
  always_comb begin
    flags_body   = 1'b0;
    flags_status = StatusProto;
    if (!write_q && in_sub == {2'b10, size_q}) begin
      flags_body = 1'b1;
    end else if (!write_q && in_sub == 4'd12 && in_last) begin
      flags_status = StatusTarget;
    end else if (write_q && in_sub == 4'd13 && in_last) begin
      flags_status = StatusOk;
    end else if (write_q && in_sub == 4'd14 && in_last) begin
      flags_status = StatusTarget;
    end
  end

  always_comb begin
    state_d        = state_q;
    tx_idx_d       = tx_idx_q;
    hdr_idx_d      = hdr_idx_q;
    body_cnt_d     = body_cnt_q;
    drop_to_resp_d = drop_to_resp_q;
    write_d        = write_q;
    dest_d         = dest_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    status_d       = status_q;
    rdata_d        = rdata_q;
    cnt_d          = cnt_q;

    if ((state_q inside {StRxHdr, StRxBody, StRxDrop}) && cnt_q != ToLimit) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          dest_d   = bus.req_dest;
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          tx_idx_d = 4'd0;
          rdata_d  = '0;
          unique case (bus.req_size)
            2'd0:    wdata_d = bus.req_wdata << 112;
            2'd1:    wdata_d = bus.req_wdata << 96;
            2'd2:    wdata_d = bus.req_wdata << 64;
            default: wdata_d = bus.req_wdata;
          endcase
          if (too_big) begin
            status_d = StatusProto;
            state_d  = StResp;
          end else begin
            status_d = StatusOk;
            state_d  = StTx;
          end
        end
      end
      StTx: begin
        if (bus.debug_out_ready) begin
          if (tx_idx_q >= 4'd4) wdata_d = wdata_q << 16;
          if (tx_idx_q == tx_last_idx) begin
            state_d   = StRxHdr;
            hdr_idx_d = 2'd0;
            cnt_d     = '0;
          end else begin
            tx_idx_d = tx_idx_q + 4'd1;
          end
        end
      end
      StRxHdr: begin
        if (timed_out && hdr_idx_q == 2'd0) begin
          status_d = StatusTmo;
          state_d  = StResp;
        end else if (in_hs) begin
          case (hdr_idx_q)
            2'd0: hdr_idx_d = in_last ? 2'd0 : 2'd1;
            2'd1: begin
              if (in_last) begin
                hdr_idx_d = 2'd0;
              end else if (bus.debug_in.data != dest_q) begin
                hdr_idx_d      = 2'd0;
                state_d        = StRxDrop;
                drop_to_resp_d = 1'b0;
              end else begin
                hdr_idx_d = 2'd2;
              end
            end
            default: begin
              hdr_idx_d = 2'd0;
              if (in_type != 2'b00) begin
                if (!in_last) begin
                  state_d        = StRxDrop;
                  drop_to_resp_d = 1'b0;
                end
              end else if (flags_body && !in_last) begin
                state_d    = StRxBody;
                body_cnt_d = 4'd0;
              end else begin
                status_d       = flags_status;
                drop_to_resp_d = 1'b1;
                state_d        = in_last ? StResp : StRxDrop;
              end
            end
          endcase
        end
      end
      StRxBody: begin
        if (in_hs) begin
          rdata_d = {rdata_q[111:0], bus.debug_in.data};
          if (body_cnt_q == nwords - 4'd1) begin
            status_d       = in_last ? StatusOk : StatusProto;
            drop_to_resp_d = 1'b1;
            state_d        = in_last ? StResp : StRxDrop;
          end else if (in_last) begin
            status_d = StatusProto;
            state_d  = StResp;
          end else begin
            body_cnt_d = body_cnt_q + 4'd1;
          end
        end
      end
      StRxDrop: begin
        if (in_hs && in_last) begin
          hdr_idx_d = 2'd0;
          state_d   = drop_to_resp_q ? StResp : StRxHdr;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Read data is only reported for a successful read.
    if (state_d == StResp && state_q != StResp && status_d != StatusOk) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      tx_idx_q       <= '0;
      hdr_idx_q      <= '0;
      body_cnt_q     <= '0;
      drop_to_resp_q <= 1'b0;
      write_q        <= 1'b0;
      dest_q         <= '0;
      addr_q         <= '0;
      size_q         <= '0;
      wdata_q        <= '0;
      status_q       <= '0;
      rdata_q        <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      tx_idx_q       <= tx_idx_d;
      hdr_idx_q      <= hdr_idx_d;
      body_cnt_q     <= body_cnt_d;
      drop_to_resp_q <= drop_to_resp_d;
      write_q        <= write_d;
      dest_q         <= dest_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      status_q       <= status_d;
      rdata_q        <= rdata_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_osd_regaccess_master.sv
// Directed bench for osd_regaccess_master: packet formats, response decoding, timeout, reset.
module tb_osd_regaccess_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] id  = 16'h0001;

  always #5 clk = ~clk;

  osd_regaccess_master_if bus ();
  osd_regaccess_master_if bus16 ();

  osd_regaccess_master #(
    .MAX_REG_SIZE  (32),
    .TIMEOUT_CYCLES(20),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id (id),
    .bus(bus)
  );

  osd_regaccess_master #(
    .MAX_REG_SIZE  (16),
    .TIMEOUT_CYCLES(20),
    .TIMEOUT_WIDTH (16)
  ) dut16 (
    .clk(clk),
    .rst(rst),
    .id (id),
    .bus(bus16)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] tx_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] pkt[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] dest, input logic [15:0] addr,
                       input logic [1:0] size, input logic [127:0] wdata);
    bus.req_write = wr;
    bus.req_dest  = dest;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    check("req_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Collects egress flits with ready held high; ncyc counts edges to the last handshake.
  task automatic get_tx(output int ncyc);
    bit done;
    done = 1'b0;
    ncyc = 0;
    tx_q.delete();
    bus.debug_out_ready = 1'b1;
    while (!done && ncyc < 40) begin
      if (bus.debug_out.valid) begin
        tx_q.push_back(bus.debug_out.data);
        done = bus.debug_out.last;
      end
      tick();
      ncyc++;
    end
    bus.debug_out_ready = 1'b0;
    check("tx_done", done, 1'b1);
  endtask

  task automatic check_tx(input string tag);
    logic [15:0] got;
    check({tag, "_nflits"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 16'hxxxx;
      check($sformatf("%s_flit%0d", tag, i), got, exp_q[i]);
    end
  endtask

  task automatic send_pkt(input string tag);
    for (int i = 0; i < pkt.size(); i++) begin
      bus.debug_in.valid = 1'b1;
      bus.debug_in.data  = pkt[i];
      bus.debug_in.last  = (i == pkt.size() - 1);
      check({tag, "_in_ready"}, bus.debug_in_ready, 1'b1);
      tick();
    end
    bus.debug_in.valid = 1'b0;
    bus.debug_in.last  = 1'b0;
  endtask

  task automatic take_resp(input string tag, input logic [1:0] st, input logic [127:0] rd);
    check({tag, "_valid"}, bus.resp_valid, 1'b1);
    check({tag, "_status"}, bus.resp_status, st);
    check({tag, "_rdata"}, bus.resp_rdata, rd);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_back_idle"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    int ncyc;
    int cyc;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_dest = '0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    bus.debug_out_ready = 1'b0; bus.debug_in = '0;
    bus16.req_valid = 1'b0; bus16.req_write = 1'b0; bus16.req_dest = 16'h0005;
    bus16.req_addr = '0; bus16.req_size = '0; bus16.req_wdata = '0; bus16.resp_ready = 1'b0;
    bus16.debug_out_ready = 1'b1; bus16.debug_in = '0;

    // Reset state
    repeat (3) tick();
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_status", bus.resp_status, 2'd0);
    check("rst_resp_rdata", bus.resp_rdata, '0);
    check("rst_out_valid", bus.debug_out.valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    rst = 1'b1;
    tick();

    // 16-bit write
    issue(1'b1, 16'h0005, 16'h0201, 2'd0, 128'hBEEF);
    check("wr_first_flit_latency", bus.debug_out.valid, 1'b1);
    get_tx(ncyc);
    check("wr_tx_cycles", ncyc, 5);
    exp_q = '{16'h0005, 16'h0001, 16'h1000, 16'h0201, 16'hBEEF};
    check_tx("wr");
    pkt = '{16'h0001, 16'h0005, 16'h3400};
    send_pkt("wr");
    take_resp("wr", 2'd0, '0);

    // 32-bit read
    issue(1'b0, 16'h0005, 16'h0010, 2'd1, '0);
    get_tx(ncyc);
    check("rd32_tx_cycles", ncyc, 4);
    exp_q = '{16'h0005, 16'h0001, 16'h0400, 16'h0010};
    check_tx("rd32");
    pkt = '{16'h0001, 16'h0005, 16'h2400, 16'h1234, 16'h5678};
    send_pkt("rd32");
    take_resp("rd32", 2'd0, 128'h1234_5678);

    // Target error on read and on write
    issue(1'b0, 16'h0005, 16'h0020, 2'd0, '0);
    get_tx(ncyc);
    pkt = '{16'h0001, 16'h0005, 16'h3000};
    send_pkt("rderr");
    take_resp("rderr", 2'd1, '0);
    issue(1'b1, 16'h0005, 16'h0021, 2'd0, 128'h1111);
    get_tx(ncyc);
    pkt = '{16'h0001, 16'h0005, 16'h3800};
    send_pkt("wrerr");
    take_resp("wrerr", 2'd1, '0);

    // Stray packet from another source, then the real response
    issue(1'b0, 16'h0005, 16'h0030, 2'd0, '0);
    get_tx(ncyc);
    pkt = '{16'h0001, 16'h0009, 16'h2000, 16'hAAAA};
    send_pkt("stray");
    check("stray_no_resp", bus.resp_valid, 1'b0);
    pkt = '{16'h0001, 16'h0005, 16'h2000, 16'h4321};
    send_pkt("stray_real");
    take_resp("stray_real", 2'd0, 128'h4321);

    // Timeout with no reply, then a late reply swallowed in IDLE
    issue(1'b0, 16'h0005, 16'h0040, 2'd0, '0);
    get_tx(ncyc);
    cyc = 0;
    while (!bus.resp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, 20);
    take_resp("tmo", 2'd2, '0);
    pkt = '{16'h0001, 16'h0005, 16'h2000, 16'h9999};
    send_pkt("late");
    check("late_no_resp", bus.resp_valid, 1'b0);
    check("late_req_ready", bus.req_ready, 1'b1);

    // Local reject: 64-bit on the 32-bit instance, 32-bit on the 16-bit instance
    issue(1'b0, 16'h0005, 16'h0050, 2'd2, '0);
    check("rej64_no_flit", bus.debug_out.valid, 1'b0);
    take_resp("rej64", 2'd3, '0);
    bus16.req_size  = 2'd1;
    bus16.req_valid = 1'b1;
    tick();
    bus16.req_valid = 1'b0;
    check("rej32_resp_valid", bus16.resp_valid, 1'b1);
    check("rej32_status", bus16.resp_status, 2'd3);
    repeat (3) tick();
    check("rej32_no_flit", bus16.debug_out.valid, 1'b0);
    bus16.resp_ready = 1'b1;
    tick();
    bus16.resp_ready = 1'b0;
    check("rej32_idle", bus16.req_ready, 1'b1);

    // Protocol errors: missing data word, extra data word
    issue(1'b0, 16'h0005, 16'h0060, 2'd1, '0);
    get_tx(ncyc);
    pkt = '{16'h0001, 16'h0005, 16'h2400, 16'h1234};
    send_pkt("short");
    take_resp("short", 2'd3, '0);
    issue(1'b0, 16'h0005, 16'h0061, 2'd0, '0);
    get_tx(ncyc);
    pkt = '{16'h0001, 16'h0005, 16'h2000, 16'h1111, 16'h2222};
    send_pkt("extra");
    take_resp("extra", 2'd3, '0);

    // 32-bit write: data words MSB first
    issue(1'b1, 16'h0007, 16'h0070, 2'd1, 128'hCAFE_F00D);
    get_tx(ncyc);
    exp_q = '{16'h0007, 16'h0001, 16'h1400, 16'h0070, 16'hCAFE, 16'hF00D};
    check_tx("wr32");
    pkt = '{16'h0001, 16'h0007, 16'h3400};
    send_pkt("wr32");
    take_resp("wr32", 2'd0, '0);

    // Reset in the middle of TX
    issue(1'b1, 16'h0005, 16'h0080, 2'd0, 128'h5555);
    tick();
    tick();
    check("midtx_valid", bus.debug_out.valid, 1'b1);
    rst = 1'b0;
    tick();
    check("midtx_rst_valid", bus.debug_out.valid, 1'b0);
    check("midtx_rst_ready", bus.req_ready, 1'b1);
    rst = 1'b1;
    tick();
    issue(1'b0, 16'h0005, 16'h0090, 2'd0, '0);
    get_tx(ncyc);
    exp_q = '{16'h0005, 16'h0001, 16'h0000, 16'h0090};
    check_tx("post_rst");
    pkt = '{16'h0001, 16'h0005, 16'h2000, 16'h0ACE};
    send_pkt("post_rst");
    take_resp("post_rst", 2'd0, 128'h0ACE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/osd_regaccess_master.md
Name: osd_regaccess_master

Overview:
Initiator side of the OSD debug register-access protocol. Takes one register read/write command from local logic and emits a REG request packet on its DII egress port. Then waits on its DII ingress port for the matching response, checks it, and returns read data and status. It is used by debug modules that must program registers of other modules, for example a host bridge or a trigger controller.

Parameters:
MAX_REG_SIZE, 16, largest supported access in bits (16, 32, 64 or 128); sizes above this are rejected locally
TIMEOUT_CYCLES, 1024, cycles to wait for a response; 0 disables the timeout
TIMEOUT_WIDTH, 16, width of the timeout counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low; all state returns to IDLE
id  in  16  own DII address, sent as SRC
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready
req_write  in  1  1 = write, 0 = read
req_dest  in  16  target module address
req_addr  in  16  register address
req_size  in  2  0:16b, 1:32b, 2:64b, 3:128b
req_wdata  in  128  write data, right-aligned
resp_valid  out  1  result valid, held until resp_ready
resp_ready  in  1  result consumed
resp_status  out  2  0 OK, 1 target error, 2 timeout, 3 local/protocol error
resp_rdata  out  128  read data, right-aligned, zero-extended
debug_out  out  dii_flit  request packet flits (valid, last, data[15:0])
debug_out_ready  in  1  egress ready
debug_in  in  dii_flit  response packet flits
debug_in_ready  out  1  ingress ready

Behaviour:
- Reset (rst==0 at posedge): state IDLE, resp_valid=0, resp_status=0, resp_rdata=0, debug_out.valid=0, timeout counter=0. A packet in flight is abandoned. After reset, DII flits of that packet are drained as foreign packets.
- IDLE: req_ready=1, debug_in_ready=1. Every ingress flit received in IDLE is discarded (stale or late responses).
- Command acceptance:
  - On req_valid&req_ready, latch all req_* inputs.
  - If 16<<req_size > MAX_REG_SIZE: no packet is sent; go to RESP with status 3 on the next cycle.
  - Otherwise go to TX.
- TX: debug_out.valid=1; a flit advances only on debug_out_ready. Flit sequence:
  - DEST = req_dest
  - SRC = id
  - FLAGS = {TYPE=2'b00, TYPE_SUB, 10'b0}, with TYPE_SUB = size for a read and 4+size for a write
  - ADDR = req_addr
  - for writes only: N = 1<<size data words, most significant word first (word k = wdata[16*(N-k)-1 -: 16])
  - last=1 on the final flit
  - The first flit is presented the cycle after acceptance. debug_in_ready=1 in TX, and flits arriving during TX are discarded.
- RX_HDR: entered after the last TX flit handshakes. The timeout counter clears, then increments every cycle until RESP. debug_in_ready=1.
  - Flit 0 (DEST) is ignored.
  - Flit 1 (SRC) must equal req_dest.
  - Flit 2 (FLAGS) must have TYPE==0.
  - If either check fails: go to RX_DROP and consume until last, then return to RX_HDR. The timeout counter keeps running.
  - A packet ending (last) before FLAGS is also dropped.
- FLAGS evaluation for a matched packet:
  - Read access: TYPE_SUB==8+size gives read success; the body is N words, MSB first, shifted into rdata, and the word is status 0 only if last arrives exactly on word N.
  - Read access: TYPE_SUB==12 with last on FLAGS gives status 1.
  - Write access: TYPE_SUB==13 gives status 0; TYPE_SUB==14 gives status 1. In both cases last must be on FLAGS.
  - Any other subtype, early last, or extra flits gives status 3. Remaining flits are drained in RX_DROP before entering RESP.
- Timeout: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES while waiting in RX_HDR at a packet boundary, go to RESP with status 2. If the timeout hits mid-packet, it applies after that packet's last flit.
- RESP: resp_valid=1. resp_rdata is meaningful only for successful reads and is 0 otherwise. On resp_ready, go to IDLE the next cycle. A new command can be accepted in that IDLE cycle at the earliest, so there is one outstanding transaction.
- Minimum latency for a 16-bit read: acceptance at T, DEST at T+1, ADDR handshake at T+4. The response FLAGS (last) handshake at cycle R gives resp_valid at R+1.

Test Plan:
- Write: req write, dest=0x0005, addr=0x0201, size=0, wdata=0xBEEF, id=0x0001. Egress must be 0x0005, 0x0001, 0x1000, 0x0201, 0xBEEF with last on the 5th flit. Reply {0x0001, 0x0005, 0x3400(last)} must give resp status 0.
- 32-bit read (MAX_REG_SIZE=32): egress FLAGS must be 0x0400. Reply {0x0001, 0x0005, 0x2400, 0x1234, 0x5678(last)} must give rdata=0x12345678, status 0.
- Target error: a 16-bit read answered with FLAGS 0x3000 (last) must give status 1, rdata=0. A write answered with 0x3800 must give status 1.
- Stray packet dropped: during RX_HDR, a 4-flit packet with SRC=0x0009 is consumed with debug_in_ready=1 and ignored. The real response that follows must complete with status 0.
- Timeout: TIMEOUT_CYCLES=20 with no reply must give resp_valid exactly 20 cycles after RX entry, with status 2. A late reply must then be silently discarded in IDLE.
- Local reject / protocol error / reset: size=1 with MAX_REG_SIZE=16 must give status 3 and no egress flits. A read-success reply missing one data word must give status 3. rst low mid-TX must drop debug_out.valid the next cycle with req_ready=1.
